// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_seq_pkg
// Purpose  : Shared types and default geometry for the SPI transaction
//            sequencer and its command/response FIFOs.
// Contents : seq_state_t : sequencer FSM states
//            spi_cmd_t   : {slave, data} FIFO entry layout (default geometry)
//            c_DEFAULT_* : default word width / slave count
// Revision : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 8;
    localparam int c_DEFAULT_NUM_SLAVES = 4;
    localparam int c_DEFAULT_SS_W       = $clog2(c_DEFAULT_NUM_SLAVES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        STORE  = 2'd3
    } seq_state_t;

    // Both FIFOs store entries in this field order: slave index in the upper
    // bits, data byte in the lower bits.
    typedef struct packed {
        logic [c_DEFAULT_SS_W-1:0]       slave;
        logic [c_DEFAULT_DATA_WIDTH-1:0] data;
    } spi_cmd_t;

endpackage
`default_nettype wire

// File: rtl/spi_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_seq_fifo
// Purpose  : First-word fall-through FIFO with wrap-around pointers (one
//            extra MSB distinguishes full from empty).
// Ports    : clk, rst_n      - clock, synchronous active-low reset
//            push, push_data - write request (ignored while full)
//            pop             - read request (ignored while empty)
//            pop_data        - head entry; reads as zero while empty
//            count           - current occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module spi_seq_fifo #(
    parameter int  WIDTH = 10,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    // Same slot index but different lap bit means the writer is a full lap ahead.
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop && !w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;

    // Gating keeps the head at zero after reset and whenever nothing is stored.
    assign pop_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_sequencer
// Purpose  : Buffers {slave, byte} commands, launches one SPI master
//            transaction per command and returns each received byte, tagged
//            with its slave index, through a response FIFO.
// Ports    : clk, rst_n                          - clock, sync active-low reset
//            cmd_valid/cmd_ready/cmd_data/cmd_slave - command push side
//            rsp_valid/rsp_ready/rsp_data/rsp_slave - response pop side
//            busy                                - FSM active or commands queued
//            start_transaction/tx_data/slave_select - to SPI master
//            rx_data/transaction_done            - from SPI master
//            timeout_err                         - sticky watchdog flag
// Options  : SPI_SEQ_TIMEOUT_EN - adds a WAIT watchdog of TIMEOUT_CYCLES and
//            the timeout_err port; without it WAIT waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int  DATA_WIDTH     = c_DEFAULT_DATA_WIDTH,
    parameter int  NUM_SLAVES     = c_DEFAULT_NUM_SLAVES,
    parameter int  FIFO_DEPTH     = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int SS_W           = $clog2(NUM_SLAVES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [SS_W-1:0]       cmd_slave,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [SS_W-1:0]       rsp_slave,
    output logic                  busy,
`ifdef SPI_SEQ_TIMEOUT_EN
    output logic                  timeout_err,
`endif
    output logic                  start_transaction,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [SS_W-1:0]       slave_select,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  transaction_done
);

    localparam int c_ENTRY_W = SS_W + DATA_WIDTH;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH) + 1;

    seq_state_t             r_state;
    logic                   r_start;
    logic [DATA_WIDTH-1:0]  r_tx_data;
    logic [SS_W-1:0]        r_slave;
    logic [DATA_WIDTH-1:0]  r_rx_word;

    logic [c_ENTRY_W-1:0]   w_tx_head;
    logic [c_ENTRY_W-1:0]   w_rx_head;
    logic [c_CNT_W-1:0]     w_tx_count;
    logic [c_CNT_W-1:0]     w_rx_count;
    logic                   w_tx_empty;
    logic                   w_tx_full;
    logic                   w_rx_full;
    logic                   w_cmd_push;
    logic                   w_tx_pop;
    logic                   w_rx_push;
    logic                   w_rx_pop;
    logic                   w_timeout_hit;

    assign w_tx_empty = (w_tx_count == '0);
    assign w_tx_full  = (w_tx_count == c_CNT_W'(FIFO_DEPTH));
    assign w_rx_full  = (w_rx_count == c_CNT_W'(FIFO_DEPTH));

    assign cmd_ready  = !w_tx_full;
    assign w_cmd_push = cmd_valid && cmd_ready;
    assign rsp_valid  = (w_rx_count != '0);
    assign w_rx_pop   = rsp_valid && rsp_ready;
    assign {rsp_slave, rsp_data} = w_rx_head;

    // At most one transaction is in flight and its response is pushed in
    // STORE, before IDLE is re-entered; so in IDLE "RX not full" already
    // includes the slot reserved for the transaction about to launch.
    assign w_tx_pop  = (r_state == IDLE) && !w_tx_empty && !w_rx_full;
    assign w_rx_push = (r_state == STORE);

    assign busy              = (r_state != IDLE) || !w_tx_empty;
    assign start_transaction = r_start;
    assign tx_data           = r_tx_data;
    assign slave_select      = r_slave;

    spi_seq_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_cmd_push),
        .push_data ({cmd_slave, cmd_data}),
        .pop       (w_tx_pop),
        .pop_data  (w_tx_head),
        .count     (w_tx_count)
    );

    spi_seq_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_rx_push),
        .push_data ({r_slave, r_rx_word}),
        .pop       (w_rx_pop),
        .pop_data  (w_rx_head),
        .count     (w_rx_count)
    );

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int c_TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TMR_W-1:0] r_timer;
    logic               r_timeout_err;

    // A done pulse on the final watchdog cycle still wins over the timeout.
    assign w_timeout_hit = (r_state == WAIT) && !transaction_done &&
                           (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err   = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timer <= (r_state == WAIT) ? r_timer + 1'b1 : '0;
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_tx_data <= '0;
            r_slave   <= '0;
            r_rx_word <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tx_pop) begin
                        {r_slave, r_tx_data} <= w_tx_head;
                        r_start              <= 1'b1;
                        r_state              <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_start <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (transaction_done) begin
                        r_rx_word <= rx_data;
                        r_state   <= STORE;
                    end else if (w_timeout_hit) begin
                        r_rx_word <= '0;
                        r_state   <= STORE;
                    end
                end
                STORE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_sequencer
// Purpose  : Self-checking bench for spi_txn_sequencer. An SPI master model
//            answers each launch; queues hold the commands and responses the
//            design must reproduce in order. Directed cases cover latency,
//            TX fill, RX backpressure and mid-transaction reset, followed by
//            a randomized traffic phase. Timeout cases build only with
//            SPI_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_txn_sequencer;

    localparam int DW    = 8;
    localparam int NS    = 4;
    localparam int SW    = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int EW    = SW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_slave;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [SW-1:0] rsp_slave;
    logic          busy;
    logic          start_transaction;
    logic [DW-1:0] tx_data;
    logic [SW-1:0] slave_select;
    logic [DW-1:0] rx_data;
    logic          transaction_done;
`ifdef SPI_SEQ_TIMEOUT_EN
    logic          timeout_err;
`endif

    always #5 clk = ~clk;

    spi_txn_sequencer #(
        .DATA_WIDTH     (DW),
        .NUM_SLAVES     (NS),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_data          (cmd_data),
        .cmd_slave         (cmd_slave),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .rsp_slave         (rsp_slave),
        .busy              (busy),
`ifdef SPI_SEQ_TIMEOUT_EN
        .timeout_err       (timeout_err),
`endif
        .start_transaction (start_transaction),
        .tx_data           (tx_data),
        .slave_select      (slave_select),
        .rx_data           (rx_data),
        .transaction_done  (transaction_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model state: accepted commands awaiting launch, responses
    // awaiting pop, and the single transaction the master is serving.
    logic [EW-1:0] exp_cmd [$];
    logic [EW-1:0] exp_rsp [$];
    bit            pend        = 1'b0;
    int            pend_wait   = 0;
    logic [DW-1:0] pend_rx;
    logic [EW-1:0] cur_tx;
    bit            master_stall = 1'b0;
    bit            rnd_delay    = 1'b0;
    bit            use_fixed    = 1'b0;
    bit            inject_done  = 1'b0;
    logic [DW-1:0] fixed_rx     = '0;

    int            n_start = 0;
    int            n_push  = 0;
    int            push_cyc, start_cyc, done_cyc, rise_cyc;
    bit            prev_start, prev_rsp_valid, prev_pop;
    logic [EW-1:0] prev_rsp;
    logic [EW-1:0] last_rsp;
`ifdef SPI_SEQ_TIMEOUT_EN
    int            err_rise_cyc = 0;
    bit            prev_err     = 1'b0;
`endif

    // Monitor: samples on the falling edge, between driver updates.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_start     = 1'b0;
            prev_rsp_valid = 1'b0;
            prev_pop       = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                exp_cmd.push_back({cmd_slave, cmd_data});
                push_cyc = cyc;
                n_push++;
            end
            if (start_transaction) begin
                check("start_one_cycle", 32'(prev_start), 32'(0));
                check("start_has_cmd", 32'(exp_cmd.size() != 0), 32'(1));
                if (exp_cmd.size() != 0)
                    check("launched_cmd", 32'({slave_select, tx_data}), 32'(exp_cmd.pop_front()));
                n_start++;
                start_cyc = cyc;
                cur_tx    = {slave_select, tx_data};
                pend      = 1'b1;
                pend_wait = rnd_delay ? int'($urandom_range(0, 4)) : 0;
                pend_rx   = use_fixed ? fixed_rx : DW'($urandom);
            end
            if (prev_rsp_valid && !prev_pop)
                check("rsp_held", 32'({rsp_valid, rsp_slave, rsp_data}), 32'({1'b1, prev_rsp}));
            if (rsp_valid && !prev_rsp_valid)
                rise_cyc = cyc;
            if (rsp_valid && rsp_ready) begin
                check("rsp_has_txn", 32'(exp_rsp.size() != 0), 32'(1));
                if (exp_rsp.size() != 0)
                    check("rsp_word", 32'({rsp_slave, rsp_data}), 32'(exp_rsp.pop_front()));
                last_rsp = {rsp_slave, rsp_data};
            end
            prev_start     = start_transaction;
            prev_rsp_valid = rsp_valid;
            prev_pop       = rsp_valid && rsp_ready;
            prev_rsp       = {rsp_slave, rsp_data};
`ifdef SPI_SEQ_TIMEOUT_EN
            if (timeout_err && !prev_err) err_rise_cyc = cyc;
            prev_err = timeout_err;
`endif
        end
    end

    // SPI master model: answers the pending launch after a (possibly random)
    // delay with a single-cycle done pulse.
    initial begin
        transaction_done = 1'b0;
        rx_data          = '0;
        forever begin
            @(posedge clk);
            #1;
            transaction_done = 1'b0;
            if (inject_done) begin
                transaction_done = 1'b1;
                rx_data          = 8'hEE;
                inject_done      = 1'b0;
            end else if (pend && !master_stall && rst_n) begin
                if (pend_wait > 0) begin
                    pend_wait--;
                end else begin
                    check("tx_held", 32'({slave_select, tx_data}), 32'(cur_tx));
                    transaction_done = 1'b1;
                    rx_data          = pend_rx;
                    exp_rsp.push_back({cur_tx[EW-1:DW], pend_rx});
                    pend     = 1'b0;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},    32'(cmd_ready),         32'(1));
        check({tag, "_rsp_valid"},    32'(rsp_valid),         32'(0));
        check({tag, "_busy"},         32'(busy),              32'(0));
        check({tag, "_start"},        32'(start_transaction), 32'(0));
        check({tag, "_tx_data"},      32'(tx_data),           32'(0));
        check({tag, "_slave_select"}, 32'(slave_select),      32'(0));
        check({tag, "_rsp_data"},     32'(rsp_data),          32'(0));
        check({tag, "_rsp_slave"},    32'(rsp_slave),         32'(0));
`ifdef SPI_SEQ_TIMEOUT_EN
        check({tag, "_timeout_err"},  32'(timeout_err),       32'(0));
`endif
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        step(2);
        exp_cmd.delete();
        exp_rsp.delete();
        pend        = 1'b0;
        inject_done = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_cmd(input logic [SW-1:0] s, input logic [DW-1:0] d);
        int guard;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_slave = s;
        cmd_data  = d;
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("push_accepted", 32'(cmd_ready), 32'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((busy || rsp_valid || pend || exp_cmd.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_drained"},  32'(guard < 2000),    32'(1));
        check({tag, "_rsp_left"}, 32'(exp_rsp.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int push_base;
        int guard;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_slave = '0;
        rsp_ready = 1'b0;
        apply_reset();

        // Single command with fixed response: latency and tagging.
        rsp_ready = 1'b1;
        use_fixed = 1'b1;
        fixed_rx  = 8'h3C;
        base      = n_start;
        push_cmd(2'd2, 8'hA5);
        wait_drain("single");
        check("single_starts",         32'(n_start - base),       32'(1));
        check("single_launch_latency", 32'(start_cyc - push_cyc), 32'(2));
        check("single_rsp_latency",    32'(rise_cyc - done_cyc),  32'(2));
        check("single_rsp",            32'(last_rsp),             32'({2'd2, 8'h3C}));
        use_fixed = 1'b0;

        // Fill TX while the master is stalled: one in flight plus DEPTH queued.
        master_stall = 1'b1;
        base         = n_start;
        for (int i = 1; i <= 5; i++) push_cmd(SW'(i - 1), DW'(i));
        @(negedge clk);
        check("fill_cmd_ready", 32'(cmd_ready),      32'(0));
        check("fill_busy",      32'(busy),           32'(1));
        check("fill_starts",    32'(n_start - base), 32'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_slave = 2'd1;
        cmd_data  = 8'h06;
        step(3);
        @(negedge clk);
        check("fill_refused",   32'(cmd_ready),      32'(0));
        check("fill_queued",    32'(exp_cmd.size()), 32'(4));
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
        master_stall = 1'b0;
        wait_drain("fill");
        check("fill_starts_total", 32'(n_start - base), 32'(5));

        // RX backpressure: only DEPTH transactions may complete.
        rsp_ready = 1'b0;
        base      = n_start;
        for (int i = 0; i < 6; i++) push_cmd(SW'($urandom), DW'(8'h10 + i));
        step(30);
        @(negedge clk);
        check("bp_starts",    32'(n_start - base), 32'(4));
        check("bp_rsp_valid", 32'(rsp_valid),      32'(1));
        check("bp_busy",      32'(busy),           32'(1));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain("bp");
        check("bp_starts_total", 32'(n_start - base), 32'(6));

        // Randomized traffic with random master delay and consumer stalls.
        rnd_delay = 1'b1;
        base      = n_start;
        push_base = n_push;
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_data  = DW'($urandom);
            cmd_slave = SW'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            step(1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain("random");
        check("random_launches", 32'(n_start - base), 32'(n_push - push_base));
        rnd_delay = 1'b0;

        // Reset in WAIT abandons the transaction; a later done is ignored.
        master_stall = 1'b1;
        base         = n_start;
        push_cmd(2'd1, 8'h77);
        guard = 0;
        while (n_start == base && guard < 20) begin
            step(1);
            guard++;
        end
        check("midrst_launched", 32'(n_start - base), 32'(1));
        step(3);
        rst_n = 1'b0;
        step(1);
        @(negedge clk);
        check_reset_outputs("midrst");
        pend = 1'b0;
        exp_cmd.delete();
        exp_rsp.delete();
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        master_stall = 1'b0;
        inject_done  = 1'b1;
        step(4);
        @(negedge clk);
        check("late_done_rsp_valid", 32'(rsp_valid),         32'(0));
        check("late_done_busy",      32'(busy),              32'(0));
        check("late_done_start",     32'(start_transaction), 32'(0));
        check("late_done_starts",    32'(n_start - base),    32'(1));
        @(posedge clk);
        #1;

`ifdef SPI_SEQ_TIMEOUT_EN
        // Watchdog: no done ever arrives.
        master_stall = 1'b1;
        rsp_ready    = 1'b1;
        push_cmd(2'd3, 8'h5A);
        guard = 0;
        while (!timeout_err && guard < TMO + 40) begin
            step(1);
            guard++;
        end
        check("tmo_flag", 32'(timeout_err), 32'(1));
        exp_rsp.push_back({2'd3, 8'h00});
        pend         = 1'b0;
        master_stall = 1'b0;
        wait_drain("tmo");
        check("tmo_latency", 32'(err_rise_cyc - start_cyc), 32'(TMO + 1));
        check("tmo_rsp",     32'(last_rsp),                 32'({2'd3, 8'h00}));
        check("tmo_sticky",  32'(timeout_err),              32'(1));
        apply_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
